cla_subtractor_16bit_seq: RTL and testbench

- Multi-cycle 16-bit subtractor: computes D = A - B - Bin as A + ~B + ~Bin.
- Processes one 4-bit nibble per cycle through a single carry-look-ahead slice with inverted B operand; borrow ripples between cycles through a carry register.
- Inverse-direction companion to the team's 16-bit CLA adder.
- Valid/ready handshake on input and output; sits in datapaths that trade area for latency.

---
 rtl/cla_subtractor_16bit_seq_pkg.sv | 21 ++
 rtl/cla_subtractor_16bit_seq_if.sv | 29 ++
 rtl/cla_subtractor_16bit_seq_slice.sv | 32 +++
 rtl/cla_subtractor_16bit_seq.sv | 122 ++++++++++++
 tb/tb_cla_subtractor_16bit_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cla_subtractor_16bit_seq_pkg.sv
// Shared types and defaults for the nibble-serial CLA subtractor.
// Holds state encodings, size defaults and the overflow helper.
package cla_subtractor_16bit_seq_pkg;

  localparam int PKG_WIDTH  = 16;
  localparam int PKG_SLICE  = 4;
  localparam int PKG_NSLICE = PKG_WIDTH / PKG_SLICE;
  localparam int PKG_IDX_W  = (PKG_NSLICE > 1) ? $clog2(PKG_NSLICE) : 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Signed overflow of a - b: operands differ in sign and the result sign left a's.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    sub_ovf = (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/cla_subtractor_16bit_seq_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The master drives operands and out_ready; the slave is the subtractor.
interface cla_subtractor_16bit_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             Zero;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, Zero, Ovf
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, Zero, Ovf
  );

endinterface

// File: rtl/cla_subtractor_16bit_seq_slice.sv
// Combinational 4-bit carry-look-ahead slice computing A + ~B + Cin.
// Carries come from flattened generate/propagate terms rather than a ripple chain.
module cla_sub_slice_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] w_bn;
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;

  assign w_bn = ~B;
  assign w_g  = A & w_bn;
  assign w_p  = A ^ w_bn;

  assign w_c1 = w_g[0] | (w_p[0] & Cin);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign Cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  assign S = w_p ^ {w_c3, w_c2, w_c1, Cin};

endmodule

// File: rtl/cla_subtractor_16bit_seq.sv
// Nibble-serial 16-bit subtractor: D = A + ~B + ~Bin, one CLA slice per cycle.
// The carry register links nibbles across cycles; all outputs are registered.
module cla_subtractor_16bit_seq
  import cla_subtractor_16bit_seq_pkg::*;
#(
  parameter int WIDTH = PKG_WIDTH,
  parameter int SLICE = PKG_SLICE
) (
  input  logic                        clk,
  input  logic                        rst,
  cla_subtractor_16bit_seq_if.slave   bus
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_bout;
  logic             r_zero;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [SLICE-1:0] w_a_nib;
  logic [SLICE-1:0] w_b_nib;
  logic [SLICE-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_d_next;
  logic             w_last;

  assign w_a_nib = r_a[r_idx*SLICE +: SLICE];
  assign w_b_nib = r_b[r_idx*SLICE +: SLICE];
  assign w_last  = (r_idx == IW'(NSL - 1));

  cla_sub_slice_4bit u_slice (
    .A    (w_a_nib),
    .B    (w_b_nib),
    .Cin  (r_carry),
    .S    (w_sum),
    .Cout (w_cout)
  );

  // Merge this cycle's nibble into the result so flags see the complete word on the last step.
  always_comb begin
    w_d_next = r_d;
    w_d_next[r_idx*SLICE +: SLICE] = w_sum;
  end

  // Handshake FSM plus operand, carry and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_d         <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_idx       <= {IW{1'b0}};
      r_bout      <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.A;
            r_b        <= bus.B;
            r_carry    <= ~bus.Bin;
            r_idx      <= {IW{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= ST_CALC;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_CALC: begin
          r_d     <= w_d_next;
          r_carry <= w_cout;
          if (w_last) begin
            // Carry-out of A + ~B + ~Bin is the inverse of the borrow.
            r_bout      <= ~w_cout;
            r_zero      <= (w_d_next == {WIDTH{1'b0}});
            r_ovf       <= sub_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_d_next[WIDTH-1]);
            r_idx       <= {IW{1'b0}};
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.D         = r_d;
  assign bus.Bout      = r_bout;
  assign bus.Zero      = r_zero;
  assign bus.Ovf       = r_ovf;

endmodule

// File: tb/tb_cla_subtractor_16bit_seq.sv
// Self-checking bench for cla_subtractor_16bit_seq: directed cases, backpressure,
// mid-operation reset and a random sweep against an arithmetic reference model.
module tb_cla_subtractor_16bit_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cla_subtractor_16bit_seq_if #(.WIDTH(16)) bus ();

  cla_subtractor_16bit_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {Bout, D} = A - B - Bin in 17-bit unsigned arithmetic.
  task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                           output logic [15:0] d, output logic bout,
                           output logic zero, output logic ovf);
    logic [16:0] full;
    int sa, sb, sd;
    full = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    d    = full[15:0];
    bout = full[16];
    zero = (d == 16'd0);
    sa = $signed(a);
    sb = $signed(b);
    sd = sa - sb;
    ovf = (sd > 32767) || (sd < -32768);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_D"},         {16'd0, bus.D},         32'd0);
    check({tag, "_Bout"},      {31'd0, bus.Bout},      32'd0);
    check({tag, "_Zero"},      {31'd0, bus.Zero},      32'd0);
    check({tag, "_Ovf"},       {31'd0, bus.Ovf},       32'd0);
  endtask

  // Accept one operand set, wait for the result, check it, stall, then release it.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input int stall);
    logic [15:0] ed;
    logic eb, ez, eo;
    int t;
    int lat;
    ref_model(a, b, bin, ed, eb, ez, eo);
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("wait_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.A   = a;
    bus.B   = b;
    bus.Bin = bin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 32'd4);
    check("D",    {16'd0, bus.D},    {16'd0, ed});
    check("Bout", {31'd0, bus.Bout}, {31'd0, eb});
    check("Zero", {31'd0, bus.Zero}, {31'd0, ez});
    check("Ovf",  {31'd0, bus.Ovf},  {31'd0, eo});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_D", {16'd0, bus.D}, {16'd0, ed});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("release_ready", {31'd0, bus.in_ready},  32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb, ed;
    logic rbin, eb, ez, eo;
    int lat;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = 16'd0;
    bus.B         = 16'd0;
    bus.Bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed cases
    do_txn(16'hABF5, 16'hFEF5, 1'b0, 0);
    do_txn(16'h1234, 16'h1234, 1'b0, 0);
    do_txn(16'h0000, 16'h0000, 1'b1, 1);
    do_txn(16'h8000, 16'h0001, 1'b0, 0);
    do_txn(16'h7FFF, 16'hFFFF, 1'b0, 2);

    // Backpressure with new operands toggling while the result is held
    ref_model(16'h4321, 16'h1111, 1'b1, ed, eb, ez, eo);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 16'h4321;
    bus.B = 16'h1111;
    bus.Bin = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_latency", lat, 32'd4);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.A = 16'($urandom);
      bus.B = 16'($urandom);
      bus.Bin = 1'($urandom);
      @(posedge clk);
      #1;
      check("bp_D",        {16'd0, bus.D},         {16'd0, ed});
      check("bp_Bout",     {31'd0, bus.Bout},      {31'd0, eb});
      check("bp_in_ready", {31'd0, bus.in_ready},  32'd0);
      check("bp_valid",    {31'd0, bus.out_valid}, 32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_rel_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_rel_ready", {31'd0, bus.in_ready},  32'd1);

    // Reset during the second CALC cycle
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 16'hFFFF;
    bus.B = 16'h0001;
    bus.Bin = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (6) begin
      @(posedge clk);
      #1;
      check("midrst_no_emit", {31'd0, bus.out_valid}, 32'd0);
    end
    do_txn(16'h0005, 16'h0003, 1'b0, 0);

    // Random sweep with random output stalls
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? ra : 16'($urandom);
      rbin = 1'($urandom);
      do_txn(ra, rb, rbin, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
